// File: rtl/data_mem_access_unit.sv
// Byte/half/word load-store responder for a word-addressed valid/ready bus; build option MISALIGNED_SPLIT_EN.
// Latency: BUSYWAIT high 2 cycles aligned, 3 when split, +1 per MEM_READY=0 cycle.
// Backpressure: bus request held stable until MEM_READY; BUSYWAIT stalls the pipeline meanwhile.
module data_mem_access_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [3:0]            READ_WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [31:0]           WRITE_DATA,
  output logic [31:0]           READ_DATA,
  output logic                  BUSYWAIT,
  output logic                  MISALIGN_FAULT,
  output logic                  MEM_REQ,
  output logic                  MEM_WE,
  output logic [ADDR_WIDTH-3:0] MEM_ADDR,
  output logic [3:0]            MEM_BE,
  output logic [31:0]           MEM_WDATA,
  input  logic                  MEM_READY,
  input  logic [31:0]           MEM_RDATA
);
  typedef enum logic [1:0] {IDLE, REQ1, REQ2, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]            code_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata0_q;
  logic                  fault_q;

  function automatic logic [2:0] size_of(input logic [2:0] c);
    case (c)
      3'b000, 3'b100, 3'b011: size_of = 3'd1;
      3'b001, 3'b101, 3'b110: size_of = 3'd2;
      default:                size_of = 3'd4;
    endcase
  endfunction

  function automatic logic is_store(input logic [2:0] c);
    is_store = (c == 3'b011) || (c == 3'b110) || (c == 3'b111);
  endfunction

  logic in_fault;
  logic in_store;
  assign in_store = is_store(READ_WRITE[2:0]);
`ifdef MISALIGNED_SPLIT_EN
  assign in_fault = 1'b0;
`else
  logic [2:0] in_size;
  assign in_size  = size_of(READ_WRITE[2:0]);
  assign in_fault = ((in_size == 3'd2) && ADDRESS[0]) ||
                    ((in_size == 3'd4) && (ADDRESS[1:0] != 2'b00));
`endif

  logic [2:0]            size_q;
  logic                  store_q;
  logic                  sgn_q;
  logic [1:0]            off;
  logic [4:0]            sh_amt;
  logic [6:0]            lane_base;
  logic [6:0]            lanes;
  logic                  split;
  logic [63:0]           wshift;
  logic [ADDR_WIDTH-3:0] word_q;

  assign size_q  = size_of(code_q);
  assign store_q = is_store(code_q);
  assign sgn_q   = (code_q == 3'b000) || (code_q == 3'b001);
  assign off     = addr_q[1:0];
  assign sh_amt  = {off, 3'b000};
  assign split   = (({1'b0, off} + size_q) > 3'd4);
  assign wshift  = {32'b0, wdata_q} << sh_amt;
  assign word_q  = addr_q[ADDR_WIDTH-1:2];

  always_comb begin
    case (size_q)
      3'd1:    lane_base = 7'b0000001;
      3'd2:    lane_base = 7'b0000011;
      default: lane_base = 7'b0001111;
    endcase
    lanes = lane_base << off;
  end

  // Load result assembled from the beat arriving now plus the first beat of a split
  logic [63:0] rd64;
  logic [31:0] rsh;
  logic [31:0] load_val;
  always_comb begin
    rd64 = (state == REQ2) ? {MEM_RDATA, rdata0_q} : {32'b0, MEM_RDATA};
    rsh  = 32'(rd64 >> sh_amt);
    case (size_q)
      3'd1:    load_val = sgn_q ? {{24{rsh[7]}}, rsh[7:0]}   : {24'b0, rsh[7:0]};
      3'd2:    load_val = sgn_q ? {{16{rsh[15]}}, rsh[15:0]} : {16'b0, rsh[15:0]};
      default: load_val = rsh;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    BUSYWAIT       = 1'b0;
    MISALIGN_FAULT = 1'b0;
    MEM_REQ        = 1'b0;
    MEM_WE         = 1'b0;
    MEM_ADDR       = '0;
    MEM_BE         = '0;
    MEM_WDATA      = '0;
    case (state)
      IDLE: begin
        BUSYWAIT = READ_WRITE[3];
        if (READ_WRITE[3]) state_nxt = in_fault ? DONE : REQ1;
      end
      REQ1: begin
        BUSYWAIT  = 1'b1;
        MEM_REQ   = 1'b1;
        MEM_WE    = store_q;
        MEM_ADDR  = word_q;
        MEM_BE    = lanes[3:0];
        MEM_WDATA = wshift[31:0];
        if (MEM_READY) state_nxt = split ? REQ2 : DONE;
      end
      REQ2: begin
        BUSYWAIT  = 1'b1;
        MEM_REQ   = 1'b1;
        MEM_WE    = store_q;
        MEM_ADDR  = word_q + {{(ADDR_WIDTH-3){1'b0}}, 1'b1};
        MEM_BE    = {1'b0, lanes[6:4]};
        MEM_WDATA = wshift[63:32];
        if (MEM_READY) state_nxt = DONE;
      end
      default: begin
        MISALIGN_FAULT = fault_q;
        state_nxt      = IDLE;
      end
    endcase
    if (!RESET_N) BUSYWAIT = 1'b0;
  end

  // READ_DATA is written on the edge entering DONE so it is valid during DONE
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      code_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata0_q  <= '0;
      fault_q   <= 1'b0;
      READ_DATA <= '0;
    end else begin
      case (state)
        IDLE: if (READ_WRITE[3]) begin
          code_q  <= READ_WRITE[2:0];
          addr_q  <= ADDRESS;
          wdata_q <= WRITE_DATA;
          fault_q <= in_fault;
          if (in_fault && !in_store) READ_DATA <= '0;
        end
        REQ1: if (MEM_READY) begin
          rdata0_q <= MEM_RDATA;
          if (!split && !store_q) READ_DATA <= load_val;
        end
        REQ2: if (MEM_READY && !store_q) READ_DATA <= load_val;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/data_mem_access_unit.md
# data_mem_access_unit

Load/store responder sitting between the MEM stage and a word-addressed data-memory bus. It consumes the 4-bit READ_WRITE access code from the instruction control unit and performs the matching byte, halfword or word access over a valid/ready bus. It applies byte enables, sign- or zero-extension and lane shifting, and stalls the pipeline with BUSYWAIT until the access completes. Accesses that cross a word boundary are split into two bus transactions.

## Interface
- ADDR_WIDTH, 32: byte-address width; the bus word address is ADDR_WIDTH-2 bits.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- READ_WRITE  in  4  access code; encoding below.
- ADDRESS  in  ADDR_WIDTH  byte address from the ALU.
- WRITE_DATA  in  32  store data, right-aligned.
- READ_DATA  out  32  extended load result, registered.
- BUSYWAIT  out  1  pipeline stall request.
- MISALIGN_FAULT  out  1  one-cycle fault pulse; only active when the macro is undefined.
- MEM_REQ  out  1  bus request valid.
- MEM_WE  out  1  1 = write, 0 = read.
- MEM_ADDR  out  ADDR_WIDTH-2  word address, ADDRESS[ADDR_WIDTH-1:2].
- MEM_BE  out  4  byte enables; bit i enables byte lane i.
- MEM_WDATA  out  32  lane-shifted write data.
- MEM_READY  in  1  bus accept / read-data valid.
- MEM_RDATA  in  32  read data, valid when MEM_READY=1 and MEM_WE=0.

## Operation
- READ_WRITE encoding:
  - 0xxx: no access.
  - Loads: 1000 LB, 1001 LH, 1010 LW, 1100 LBU, 1101 LHU.
  - Stores: 1011 SB, 1110 SH, 1111 SW.
- Operand definitions:
  - Size n = 1, 2 or 4 bytes.
  - off = ADDRESS[1:0].
  - lanes = ((1<<n)-1) << off, a 7-bit value.
  - A split is required when off+n > 4.
- State machine: IDLE, REQ1, REQ2, DONE.
- IDLE:
  - If READ_WRITE[3]=1, latch code, address and data.
  - Go to REQ1, or go to DONE with a fault when the macro is undefined.
- REQ1:
  - Drive MEM_REQ=1, MEM_ADDR = word, MEM_BE = lanes[3:0].
  - MEM_WDATA = low 32 bits of (WRITE_DATA << 8*off), 64-bit shift.
  - On MEM_REQ & MEM_READY at a clock edge: capture rdata0, then go to REQ2 if a split is required, otherwise DONE.
- REQ2:
  - MEM_ADDR = word+1, wrapping modulo 2^(ADDR_WIDTH-2).
  - MEM_BE = lanes[6:4].
  - MEM_WDATA = high 32 bits of the shifted data.
  - On handshake: capture rdata1, go to DONE.
- DONE:
  - For loads, READ_DATA = low n bytes of ({rdata1, rdata0} >> 8*off); rdata1 = 0 if there was no split.
  - Sign-extend LB/LH; zero-extend LBU/LHU.
  - Stores leave READ_DATA unchanged.
  - READ_WRITE is ignored in this state; return to IDLE.
- Bus rule: MEM_REQ, MEM_WE, MEM_ADDR, MEM_BE and MEM_WDATA are held stable while MEM_REQ=1 and MEM_READY=0. MEM_REQ=0 in IDLE and DONE.
- BUSYWAIT is combinational:
  - 1 when (IDLE and READ_WRITE[3]=1), in REQ1 and in REQ2.
  - 0 in DONE and while RESET_N=0.
  - The pipeline advances at the end of the DONE cycle.
- READ_DATA holds its value until the next load completes.

## Timing
- Reset values: state IDLE; READ_DATA, MEM_ADDR, MEM_BE, MEM_WDATA = 0; MEM_REQ, MEM_WE, MISALIGN_FAULT = 0.
- Latency with MEM_READY tied to 1:
  - Aligned access: BUSYWAIT high for 2 cycles (IDLE, REQ1); DONE on the 3rd cycle.
  - Split access: BUSYWAIT high for 3 cycles.
- Each MEM_READY=0 cycle adds one cycle of latency.
- Reset mid-operation: RESET_N=0 at any edge forces IDLE and MEM_REQ=0 the next cycle. The outstanding bus request is abandoned and no retry follows.
- At most one access is in flight. A new READ_WRITE is sampled only in IDLE.

## Configuration
- MISALIGNED_SPLIT_EN defined:
  - Boundary-crossing accesses split as described.
  - An in-word unaligned halfword (off=1) is a single access.
- MISALIGNED_SPLIT_EN undefined:
  - A halfword with off[0]=1, or a word with off≠0, goes IDLE→DONE with no bus request.
  - MISALIGN_FAULT=1 during DONE; stores are suppressed; READ_DATA is set to 0.
  - REQ2 is unreachable and may be omitted.

## Test plan
- LW at 0x100, MEM_RDATA=0xDEADBEEF, READY=1 → MEM_ADDR=0x40, BE=1111, BUSYWAIT high for 2 cycles, READ_DATA=0xDEADBEEF.
- LB at 0x103 with MEM_RDATA=0x80112233 → READ_DATA=0xFFFFFF80; LBU at the same address → 0x00000080.
- SH at 0x203 with WRITE_DATA=0x0000ABCD:
  - Macro defined → two writes: (0x80, BE=1000, WDATA=0xCD000000) then (0x81, BE=0001, WDATA=0x000000AB).
  - Macro undefined → one-cycle MISALIGN_FAULT pulse, MEM_REQ never asserted.
- LW at 0x102, words 0x44332211 / 0x88776655 → READ_DATA=0x66554433, BUSYWAIT high for 3 cycles.
- SW with MEM_READY=0 for 5 cycles → MEM_REQ and MEM_ADDR/BE/WDATA stable for 6 cycles, BUSYWAIT high throughout.
- RESET_N=0 during REQ2 → next cycle in IDLE with MEM_REQ=0 and READ_DATA=0, and BUSYWAIT=0 while reset is held.
